// File: rtl/pixel_stream_pkg.sv
// Shared types and widths for the raster pixel stream transmitter.
package pixel_stream_pkg;

    localparam int unsigned COL_W   = 12;
    localparam int unsigned ROW_W   = 12;
    localparam int unsigned BLANK_W = 16;
    localparam int unsigned PIX_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } stream_state_t;

endpackage

// File: rtl/pixel_stream_gen_blank_timer.sv
// Loadable down-counter timing a blanking interval; done pulses in the last blank cycle.
module blank_timer
    import pixel_stream_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BLANK_W-1:0] len,
    output logic               done
);

    logic [BLANK_W-1:0] blank_cnt;

    // Load len-1 on the cycle entering blanking so done lands on the len-th blank cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= '0;
            done      <= 1'b0;
        end else if (load) begin
            blank_cnt <= (len == '0) ? '0 : len - BLANK_W'(1);
            done      <= (len == BLANK_W'(1));
        end else begin
            if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BLANK_W'(1);
            end
            done <= (blank_cnt == BLANK_W'(1));
        end
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// Raster-order pixel stream transmitter with programmable H/V blanking and frame flags.
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter logic [COL_W-1:0]   H_DISP  = 12'd640,
    parameter logic [ROW_W-1:0]   V_DISP  = 12'd480,
    parameter logic [COL_W-1:0]   H_BLANK = 12'd16,
    parameter logic [BLANK_W-1:0] V_BLANK = 16'd800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s_vld,
    input  logic [PIX_W-1:0] s_data,
    output logic             s_rdy,
    output logic             out_vld,
    output logic [PIX_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy
);

    localparam logic [COL_W-1:0] COL_LAST = H_DISP - COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = V_DISP - ROW_W'(1);

    stream_state_t      state;
    stream_state_t      state_nxt;
    logic [COL_W-1:0]   cnt_col;
    logic [ROW_W-1:0]   cnt_row;
    logic               accept;
    logic               last_col;
    logic               last_row;
    logic               timer_load;
    logic [BLANK_W-1:0] timer_len;
    logic               blank_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a started frame always runs to completion regardless of en.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept && last_col) begin
                    if (last_row) begin
                        state_nxt = (V_BLANK == '0) ? S_IDLE : S_VBLANK;
                    end else begin
                        state_nxt = (H_BLANK == '0) ? S_ACTIVE : S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (blank_done) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_VBLANK: begin
                if (blank_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake, position decode and blank timer control derived from the current state.
    always_comb begin
        s_rdy      = (state == S_ACTIVE);
        accept     = s_rdy && s_vld;
        last_col   = (cnt_col == COL_LAST);
        last_row   = (cnt_row == ROW_LAST);
        timer_load = accept && last_col;
        timer_len  = last_row ? V_BLANK : BLANK_W'(H_BLANK);
    end

    blank_timer u_blank_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .len   (timer_len),
        .done  (blank_done)
    );

    // Column/row position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_col <= '0;
            cnt_row <= '0;
        end else if (accept) begin
            if (last_col) begin
                cnt_col <= '0;
                cnt_row <= last_row ? '0 : cnt_row + ROW_W'(1);
            end else begin
                cnt_col <= cnt_col + COL_W'(1);
            end
        end
    end

    // Output pixel and flags, registered one cycle after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            out_eof  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            out_vld  <= accept;
            if (accept) begin
                out_data <= s_data;
            end
            out_sof  <= accept && (cnt_col == '0) && (cnt_row == '0);
            out_eol  <= accept && last_col;
            out_eof  <= accept && last_col && last_row;
            busy     <= (state_nxt != S_IDLE);
        end
    end

endmodule
